// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, branch condition codes,
// PC step size and instruction field widths.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_IDLE = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_Z      = 2'b01;
  localparam logic [1:0] BR_N      = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  localparam int PC_STEP  = 4;
  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;

  function automatic logic branch_taken(input logic [1:0] br, input logic zero, input logic neg);
    logic taken;
    case (br)
      BR_NONE:   taken = 1'b0;
      BR_Z:      taken = zero;
      BR_N:      taken = neg;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC resolution: return beats jump, jump beats a taken branch,
// otherwise fall through to the sequential address. Wraps silently.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        branch_i,
  input  logic              jump_i,
  input  logic              ret_pc_i,
  input  logic              alu_zero_i,
  input  logic              alu_neg_i,
  input  logic [ADDR_W-1:0] branch_off_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] branchPc;

  assign seqPc    = pc_i + ADDR_W'(PC_STEP);
  // The offset counts words, so it is scaled to bytes before adding.
  assign branchPc = seqPc + (branch_off_i << 2);

  always_comb begin
    next_pc_o = seqPc;
    if (ret_pc_i) begin
      next_pc_o = ret_addr_i;
    end else if (jump_i) begin
      next_pc_o = jump_addr_i;
    end else if (branch_taken(branch_i, alu_zero_i, alu_neg_i)) begin
      next_pc_o = branchPc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/valid handshake into the IR,
// and advances the PC when the control FSM pulses pc_update.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_update,
  input  logic [1:0]         branch,
  input  logic               jump,
  input  logic               ret_pc,
  input  logic               halt_pc,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic [ADDR_W-1:0]  branch_off,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic [ADDR_W-1:0]  ret_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic               instr_valid,
  output logic               halted,
  output logic               upd_dropped
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  nextPc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               instrValid_q;
  logic               imemReq_q;
  logic               halted_q;
  logic               updDropped_q;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .pc_i         (pc_q),
    .branch_i     (branch),
    .jump_i       (jump),
    .ret_pc_i     (ret_pc),
    .alu_zero_i   (alu_zero),
    .alu_neg_i    (alu_neg),
    .branch_off_i (branch_off),
    .jump_addr_i  (jump_addr),
    .ret_addr_i   (ret_addr),
    .next_pc_o    (nextPc_d)
  );

  // REQ spends one cycle arming the registered request and one cycle with it
  // high, so the request is a clean single-cycle pulse after reset or update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      imemReq_q    <= 1'b0;
      halted_q     <= 1'b0;
      updDropped_q <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (pc_update) updDropped_q <= 1'b1;
          if (!imemReq_q) begin
            imemReq_q <= 1'b1;
          end else begin
            imemReq_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pc_update) updDropped_q <= 1'b1;
          if (imem_valid) begin
            instr_q      <= imem_rdata;
            instrValid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pc_update) begin
            if (halt_pc) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              pc_q         <= nextPc_d;
              instrValid_q <= 1'b0;
              state_q      <= ST_REQ;
            end
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  assign imem_req    = imemReq_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign funct       = instr_q[FUNCT_W-1:0];
  assign instr_valid = instrValid_q;
  assign halted      = halted_q;
  assign upd_dropped = updDropped_q;

endmodule
